hps_fpga_pio_in_edge: RTL

- Parametrised Avalon-MM input PIO for HPS-visible FPGA status lines (FIFO flags, audio ready bits, etc.).
- Successor to the single-bit, address-0-only status port: WIDTH-bit inputs with a configurable synchroniser, per-bit edge capture, interrupt mask and IRQ output.
- Sits between fabric status signals and the HPS lightweight bridge.

---
 rtl/hps_fpga_pio_pkg.sv | 16 +
 rtl/hps_fpga_sync_edge.sv | 43 ++++
 rtl/hps_fpga_pio_in_edge.sv | 91 +++++++++
 3 files changed

// File: rtl/hps_fpga_pio_pkg.sv
// rtl/hps_fpga_pio_pkg.sv - shared register map and mode constants for the HPS input PIO
package hps_fpga_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/hps_fpga_sync_edge.sv
// rtl/hps_fpga_sync_edge.sv - per-vector synchroniser, previous-value register and edge select
module hps_fpga_sync_edge
    import hps_fpga_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_s,
    output logic [WIDTH-1:0] edge_det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d, sync_q;
    logic [WIDTH-1:0]                  prev_d, prev_q;
    logic [WIDTH-1:0]                  rise, fall;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
        data_s = sync_q[SYNC_STAGES-1];
        prev_d = data_s;
        rise   = data_s & ~prev_q;
        fall   = ~data_s & prev_q;
        case (EDGE_MODE)
            EDGE_RISE: edge_det = rise;
            EDGE_FALL: edge_det = fall;
            default:   edge_det = rise | fall;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/hps_fpga_pio_in_edge.sv
// rtl/hps_fpga_pio_in_edge.sv - Avalon-MM input PIO with edge capture, interrupt mask and IRQ
module hps_fpga_pio_in_edge
    import hps_fpga_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE,
    parameter int IRQ_MODE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] data_s, edge_det;
    logic [WIDTH-1:0] irqmask_d, irqmask_q;
    logic [WIDTH-1:0] edgecap_d, edgecap_q;
    logic [WIDTH-1:0] clr, rd_sel;
    logic [31:0]      readdata_d, readdata_q;
    logic [2:0]       cnt_d, cnt_q;
    logic             irq_d, irq_q;
    logic             wr, armed;
    logic             unused_wdata;

    hps_fpga_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .data_s   (data_s),
        .edge_det (edge_det)
    );

    assign unused_wdata = ^writedata;

    always_comb begin
        wr    = chipselect & ~write_n;
        // Edges are ignored until the synchroniser and prev register hold real input
        armed = (cnt_q == ARM_CNT);
        cnt_d = armed ? cnt_q : cnt_q + 3'd1;

        clr       = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        irqmask_d = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
        edgecap_d = (edgecap_q & ~clr) | (edge_det & {WIDTH{armed}});

        case (address)
            ADDR_DATA:    rd_sel = data_s;
            ADDR_IRQMASK: rd_sel = irqmask_q;
            ADDR_EDGECAP: rd_sel = edgecap_q;
            default:      rd_sel = '0;
        endcase
        readdata_d              = '0;
        readdata_d[WIDTH-1:0]   = rd_sel;

        if (IRQ_MODE == IRQ_LEVEL)
            irq_d = |(data_s & irqmask_q);
        else
            irq_d = |(edgecap_q & irqmask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
